// File: rtl/pln_dmem_responder.sv
// pln_dmem_responder: word-addressed 16-bit data memory with req/ready handshake and wait states.
// Optional MMIO register at 16'hFFFF is enabled by defining PLN_DMEM_MMIO_EN.
module pln_dmem_responder #(
    parameter int ADDR_BITS   = 8,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        mem_req,
    input  logic        mem_write,
    input  logic [15:0] mem_addr_in,
    input  logic [15:0] mem_data_in,
    output logic [15:0] mem_data_out,
    output logic        mem_ready,
    output logic        mem_err
`ifdef PLN_DMEM_MMIO_EN
    ,
    output logic [15:0] io_out,
    input  logic [15:0] io_in
`endif
);

    localparam int DEPTH = 1 << ADDR_BITS;

    typedef enum logic [1:0] {
        S_IDLE,
        S_WAIT,
        S_RESP
    } state_t;

    state_t                 r_state;
    state_t                 w_next;
    logic [3:0]             r_cnt;
    logic [15:0]            r_addr;
    logic [15:0]            r_data;
    logic                   r_write;
    logic [15:0]            r_dout;
    logic                   r_err;
    logic [15:0]            r_mem [DEPTH];
    logic                   w_commit;
    logic                   w_mmio;
    logic                   w_oor;
    logic [ADDR_BITS-1:0]   w_idx;

    assign w_idx = r_addr[ADDR_BITS-1:0];

`ifdef PLN_DMEM_MMIO_EN
    logic [15:0] r_io;

    assign w_mmio = (r_addr == 16'hFFFF);
    assign io_out = r_io;
`else
    assign w_mmio = 1'b0;
`endif

    // A shift by 16 yields zero, so ADDR_BITS=16 never flags out-of-range.
    assign w_oor    = ((r_addr >> ADDR_BITS) != 16'h0000) && !w_mmio;
    assign w_commit = (r_state == S_WAIT) && (r_cnt == 4'd0);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            S_IDLE: begin
                if (mem_req) begin
                    w_next = S_WAIT;
                end
            end
            S_WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_next = S_RESP;
                end
            end
            S_RESP: begin
                w_next = S_IDLE;
            end
            default: begin
                w_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt   <= 4'd0;
            r_addr  <= 16'h0000;
            r_data  <= 16'h0000;
            r_write <= 1'b0;
            r_dout  <= 16'h0000;
            r_err   <= 1'b0;
        end else begin
            if (r_state == S_IDLE && mem_req) begin
                r_addr  <= mem_addr_in;
                r_data  <= mem_data_in;
                r_write <= mem_write;
                r_cnt   <= 4'(WAIT_CYCLES);
            end else if (r_state == S_WAIT && r_cnt != 4'd0) begin
                r_cnt <= r_cnt - 4'd1;
            end
            if (w_commit) begin
                r_err <= w_oor;
                if (!r_write) begin
                    if (w_oor) begin
                        r_dout <= 16'h0000;
                    end else begin
`ifdef PLN_DMEM_MMIO_EN
                        r_dout <= w_mmio ? io_in : r_mem[w_idx];
`else
                        r_dout <= r_mem[w_idx];
`endif
                    end
                end
            end
        end
    end

`ifdef PLN_DMEM_MMIO_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_io <= 16'h0000;
        end else if (w_commit && r_write && w_mmio) begin
            r_io <= r_data;
        end
    end
`endif

    // Storage is not reset; an async reset forces IDLE so no commit follows it.
    always_ff @(posedge clk) begin
        if (w_commit && r_write && !w_oor && !w_mmio) begin
            r_mem[w_idx] <= r_data;
        end
    end

    assign mem_data_out = r_dout;
    assign mem_ready    = (r_state == S_RESP);
    assign mem_err      = (r_state == S_RESP) && r_err;

endmodule

// File: tb/tb_pln_dmem_responder.sv
// Bench for pln_dmem_responder: transaction-level reference model, per-cycle compare,
// directed literal cases and randomized traffic.
module tb_pln_dmem_responder;

    localparam int AB = 8;
    localparam int WC = 1;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        mem_req = 1'b0;
    logic        mem_write = 1'b0;
    logic [15:0] mem_addr_in = 16'h0000;
    logic [15:0] mem_data_in = 16'h0000;
    logic [15:0] mem_data_out;
    logic        mem_ready;
    logic        mem_err;
`ifdef PLN_DMEM_MMIO_EN
    logic [15:0] io_out;
    logic [15:0] io_in = 16'h0000;
`endif

    pln_dmem_responder #(
        .ADDR_BITS  (AB),
        .WAIT_CYCLES(WC)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .mem_req     (mem_req),
        .mem_write   (mem_write),
        .mem_addr_in (mem_addr_in),
        .mem_data_in (mem_data_in),
        .mem_data_out(mem_data_out),
        .mem_ready   (mem_ready),
        .mem_err     (mem_err)
`ifdef PLN_DMEM_MMIO_EN
        ,
        .io_out      (io_out),
        .io_in       (io_in)
`endif
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_fail = 0;
    bit cmp_en = 1'b0;

    function automatic void chk(string nm, logic [31:0] act, logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endfunction

    // Transaction model: a request accepted at edge t commits at t+WC+1,
    // is visible for one cycle, and the next one can be accepted at t+WC+3.
    int          edge_n   = 0;
    int          m_free   = 0;
    int          m_commit = 0;
    bit          m_busy   = 1'b0;
    bit          p_wr;
    logic [15:0] p_a;
    logic [15:0] p_d;
    logic [15:0] m_ram [256];
    logic [15:0] m_dout  = 16'h0000;
    bit          m_ready = 1'b0;
    bit          m_err   = 1'b0;
    logic [15:0] m_io    = 16'h0000;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_busy  = 1'b0;
            m_ready = 1'b0;
            m_err   = 1'b0;
            m_dout  = 16'h0000;
            m_free  = 0;
            m_io    = 16'h0000;
        end else begin
            bit is_io;
            bit oor;
            edge_n++;
            m_ready = 1'b0;
            m_err   = 1'b0;
            if (m_busy && edge_n == m_commit) begin
                m_busy = 1'b0;
`ifdef PLN_DMEM_MMIO_EN
                is_io = (p_a == 16'hFFFF);
`else
                is_io = 1'b0;
`endif
                oor     = ((p_a >> AB) != 0) && !is_io;
                m_ready = 1'b1;
                m_err   = oor;
                if (oor) begin
                    if (!p_wr) m_dout = 16'h0000;
                end else if (is_io) begin
`ifdef PLN_DMEM_MMIO_EN
                    if (p_wr) m_io = p_d;
                    else m_dout = io_in;
`endif
                end else if (p_wr) begin
                    m_ram[p_a[7:0]] = p_d;
                end else begin
                    m_dout = m_ram[p_a[7:0]];
                end
            end else if (!m_busy && edge_n >= m_free && mem_req) begin
                m_busy   = 1'b1;
                p_wr     = mem_write;
                p_a      = mem_addr_in;
                p_d      = mem_data_in;
                m_commit = edge_n + WC + 1;
                m_free   = edge_n + WC + 3;
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("ready", 32'(mem_ready), 32'(m_ready));
            chk("err", 32'(mem_err), 32'(m_err));
            chk("dout", 32'(mem_data_out), 32'(m_dout));
`ifdef PLN_DMEM_MMIO_EN
            chk("io_out", 32'(io_out), 32'(m_io));
`endif
        end
    end

    task automatic xact(input bit wr, input logic [15:0] a, input logic [15:0] d,
                        output int lat, output logic [15:0] rd, output bit er);
        bit got;
        got = 1'b0;
        lat = 0;
        rd  = 16'h0000;
        er  = 1'b0;
        @(negedge clk);
        mem_req     = 1'b1;
        mem_write   = wr;
        mem_addr_in = a;
        mem_data_in = d;
        while (!got && lat < 20) begin
            @(negedge clk);
            lat++;
            mem_addr_in = 16'($urandom);
            mem_data_in = 16'($urandom);
            mem_write   = 1'($urandom);
            if (mem_ready) begin
                got     = 1'b1;
                rd      = mem_data_out;
                er      = mem_err;
                mem_req = 1'b0;
            end
        end
        mem_req = 1'b0;
        chk("handshake", 32'(got), 1);
    endtask

    int          lat;
    logic [15:0] rd;
    bit          er;

    initial begin
        @(negedge clk);
        chk("rst_dout", 32'(mem_data_out), 0);
        chk("rst_ready", 32'(mem_ready), 0);
        chk("rst_err", 32'(mem_err), 0);
        #2 rst = 1'b0;
        cmp_en = 1'b1;

        for (int i = 0; i < 256; i++) begin
            xact(1'b1, 16'(i), 16'($urandom), lat, rd, er);
        end

        xact(1'b1, 16'h0012, 16'hBEEF, lat, rd, er);
        chk("wr_lat", 32'(lat), 3);
        chk("wr_err", 32'(er), 0);
        xact(1'b0, 16'h0012, 16'h0000, lat, rd, er);
        chk("rd_lat", 32'(lat), 3);
        chk("rd_data", 32'(rd), 'hBEEF);
        chk("rd_err", 32'(er), 0);

        xact(1'b1, 16'h0005, 16'h1234, lat, rd, er);
        xact(1'b0, 16'h0005, 16'h0000, lat, rd, er);
        chk("rd5", 32'(rd), 'h1234);
        xact(1'b1, 16'h0006, 16'h9999, lat, rd, er);
        chk("dout_hold_wr", 32'(rd), 'h1234);

        xact(1'b1, 16'h0000, 16'h1111, lat, rd, er);
        xact(1'b1, 16'h0100, 16'hAAAA, lat, rd, er);
        chk("oor_wr_err", 32'(er), 1);
        xact(1'b0, 16'h0100, 16'h0000, lat, rd, er);
        chk("oor_rd_err", 32'(er), 1);
        chk("oor_rd_data", 32'(rd), 0);
        xact(1'b0, 16'h0000, 16'h0000, lat, rd, er);
        chk("ram0_kept", 32'(rd), 'h1111);
        chk("ram0_err", 32'(er), 0);

        xact(1'b1, 16'h0003, 16'h0001, lat, rd, er);
        @(negedge clk);
        mem_req     = 1'b1;
        mem_write   = 1'b1;
        mem_addr_in = 16'h0003;
        mem_data_in = 16'h5555;
        @(negedge clk);
        mem_req = 1'b0;
        #2 rst = 1'b1;
        repeat (3) begin
            @(negedge clk);
            chk("rst_noready", 32'(mem_ready), 0);
        end
        chk("rst_dout_clr", 32'(mem_data_out), 0);
        #2 rst = 1'b0;
        xact(1'b0, 16'h0003, 16'h0000, lat, rd, er);
        chk("rst_no_commit", 32'(rd), 'h0001);

        @(negedge clk);
        mem_req     = 1'b1;
        mem_write   = 1'b0;
        mem_addr_in = 16'h0012;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            chk("held_ready", 32'(mem_ready), 32'((k == 3) || (k == 7)));
            if (k == 10) mem_req = 1'b0;
        end
        repeat (6) @(negedge clk);

`ifdef PLN_DMEM_MMIO_EN
        io_in = 16'h7E01;
        xact(1'b1, 16'hFFFF, 16'h00C3, lat, rd, er);
        chk("mmio_wr_err", 32'(er), 0);
        chk("mmio_io_out", 32'(io_out), 'h00C3);
        xact(1'b0, 16'hFFFF, 16'h0000, lat, rd, er);
        chk("mmio_rd", 32'(rd), 'h7E01);
`else
        xact(1'b0, 16'hFFFF, 16'h0000, lat, rd, er);
        chk("ffff_oor_err", 32'(er), 1);
        chk("ffff_oor_rd", 32'(rd), 0);
`endif

        repeat (300) begin
            logic [15:0] a;
            int          sel;
            repeat ($urandom_range(0, 2)) @(negedge clk);
            sel = int'($urandom_range(0, 7));
            if (sel == 0) a = 16'hFFFF;
            else if (sel < 3) a = 16'($urandom);
            else a = 16'($urandom_range(0, 255));
`ifdef PLN_DMEM_MMIO_EN
            io_in = 16'($urandom);
`endif
            xact(1'($urandom), a, 16'($urandom), lat, rd, er);
            chk("rand_lat", 32'(lat), 3);
        end

        repeat (4) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/pln_dmem_responder.md
Name: pln_dmem_responder

Overview:
- Data-memory responder for the PLN multi-cycle CPU; sits on the far side of the CPU's data-memory port.
- Serves single-word read and write requests with a req/ready handshake and a configurable number of wait states.
- Word-addressed 16-bit RAM with out-of-range detection. An optional memory-mapped I/O register is available at the top of the address space.

Parameters:
- ADDR_BITS, 8, number of implemented address bits; depth = 2^ADDR_BITS words of 16 bits.
- WAIT_CYCLES, 1, extra wait-state cycles inserted before each access commits (0..15).

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  reset, asynchronous, active-high.
- mem_req  input  1  request valid from CPU.
- mem_write  input  1  1 = write, 0 = read; sampled with mem_req.
- mem_addr_in  input  16  word address; sampled with mem_req.
- mem_data_in  input  16  write data; sampled with mem_req.
- mem_data_out  output  16  read data; registered.
- mem_ready  output  1  one-cycle completion pulse.
- mem_err  output  1  out-of-range flag, valid only while mem_ready=1.
- io_out  output  16  MMIO output register (present only with PLN_DMEM_MMIO_EN).
- io_in  input  16  MMIO input value (present only with PLN_DMEM_MMIO_EN).

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; mem_ready=0; mem_err=0; mem_data_out=16'h0000; wait counter=0.
  - RAM contents are not reset.
- FSM states: IDLE, WAIT, RESP.
- IDLE:
  - On a clock edge with mem_req=1, latch mem_addr_in, mem_data_in and mem_write.
  - Load counter=WAIT_CYCLES and go to WAIT.
  - With mem_req=0, stay in IDLE.
- WAIT:
  - If counter!=0, decrement and stay.
  - If counter==0, commit the access and go to RESP:
    - Write: RAM[addr] <= data.
    - Read: mem_data_out <= RAM[addr].
- RESP:
  - mem_ready=1 (registered) for exactly one cycle, then return to IDLE unconditionally.
- Latency:
  - Request sampled at edge E0; access commits at edge E0+WAIT_CYCLES+1.
  - mem_ready is high during the cycle after that edge.
  - Total cycles from sampled request to ready-high cycle: WAIT_CYCLES+2.
- Handshake:
  - The requester holds addr/data/write stable only at the sampling edge. Later changes during WAIT are ignored.
  - The requester deasserts mem_req in the cycle it observes mem_ready=1.
  - mem_req high while the FSM is in WAIT or RESP is ignored.
  - mem_req still high when the FSM re-enters IDLE is sampled as a new request at the next edge. Back-to-back throughput is one request per WAIT_CYCLES+3 cycles.
- mem_data_out:
  - Changes only on a committed in-range read (or an MMIO read).
  - Holds its value across writes, out-of-range accesses and idle periods.
- Out-of-range (mem_addr_in[15:ADDR_BITS] != 0 and not the MMIO address):
  - Read: mem_data_out <= 16'h0000.
  - Write: dropped.
  - mem_err=1 in the RESP cycle.
- ADDR_BITS=16 disables out-of-range detection.
- mem_err is 0 whenever mem_ready=0.
- Reset mid-operation:
  - The FSM aborts to IDLE with no pulse.
  - A write still in WAIT is not committed; a write already committed stays.

Optional Feature:
- Macro: PLN_DMEM_MMIO_EN.
- Defined:
  - Address 16'hFFFF is an MMIO register and never out-of-range.
  - Write to it: io_out <= data at the commit edge.
  - Read from it: mem_data_out <= io_in sampled at the commit edge.
  - io_out resets to 16'h0000.
  - This address takes precedence over RAM even when ADDR_BITS=16.
- Not defined:
  - io_out and io_in ports are absent.
  - 16'hFFFF is treated as a normal address; out-of-range when ADDR_BITS<16.

Test Plan:
- Write then read: ADDR_BITS=8, WAIT_CYCLES=1; write 16'hBEEF to addr 16'h0012, then read 16'h0012 -> read returns mem_data_out=16'hBEEF, mem_err=0. mem_ready rises exactly 3 cycles after each sampled request and lasts 1 cycle.
- Zero wait states: WAIT_CYCLES=0; write 16'h1234 to addr 5, then read addr 5 -> mem_ready in the 2nd cycle after sampling; mem_data_out=16'h1234; a following write leaves mem_data_out=16'h1234.
- Out-of-range: ADDR_BITS=8; write 16'hAAAA to addr 16'h0100, then read 16'h0100 and read 16'h0000 -> mem_err=1 with ready on both 16'h0100 accesses; first read returns 16'h0000; RAM[0] is unchanged.
- Reset during WAIT: WAIT_CYCLES=4; RAM[3] previously written 16'h0001; write 16'h5555 to addr 3 and assert rst two cycles later -> no mem_ready pulse; after reset, read addr 3 returns 16'h0001.
- Held request: mem_req held high for 10 cycles with WAIT_CYCLES=1 -> two ready pulses separated by 4 cycles; no ready while in WAIT.
- MMIO (PLN_DMEM_MMIO_EN defined): write 16'h00C3 to 16'hFFFF -> io_out=16'h00C3, mem_err=0. With io_in=16'h7E01, read 16'hFFFF -> mem_data_out=16'h7E01.
